// File: rtl/pipelined_bit_rotator.sv
// Variable-distance rotate/shift of a WIDTH-bit word as a log2(WIDTH)-stage pipeline.
// Stage k moves the word by 2^k positions when its amount bit is set.
module pipelined_bit_rotator #(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    // Handshake: a word moves across a port on a rising edge where valid && ready
    // are both high; valid never waits on ready, and in_ready never looks at in_valid.

    localparam logic [1:0] MODE_ROL = 2'b00;
    localparam logic [1:0] MODE_ROR = 2'b01;
    localparam logic [1:0] MODE_SHL = 2'b10;

    function automatic logic [WIDTH-1:0] move(
        input logic [WIDTH-1:0] x,
        input logic [1:0]       mode,
        input logic             sign,
        input int               d
    );
        logic [WIDTH-1:0] fill;
        fill = sign ? ~({WIDTH{1'b1}} >> d) : '0;
        case (mode)
            MODE_ROL: move = (x << d) | (x >> (WIDTH - d));
            MODE_ROR: move = (x >> d) | (x << (WIDTH - d));
            MODE_SHL: move = x << d;
            default:  move = (x >> d) | fill;
        endcase
    endfunction

    logic [AMT_W-1:0] src_valid;
    logic [AMT_W-1:0] src_sign;
    logic [AMT_W-1:0] stg_valid;
    logic [AMT_W-1:0] stg_sign;
    logic [AMT_W-1:0] load;
    logic [AMT_W-1:0] advance;
    logic [WIDTH-1:0] src_data [AMT_W];
    logic [WIDTH-1:0] stg_data [AMT_W];
    logic [WIDTH-1:0] stg_next [AMT_W];
    logic [AMT_W-1:0] src_amt  [AMT_W];
    logic [AMT_W-1:0] stg_amt  [AMT_W];
    logic [1:0]       src_mode [AMT_W];
    logic [1:0]       stg_mode [AMT_W];
    logic             zero_q;

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        logic             v_q;
        logic             s_q;
        logic [WIDTH-1:0] d_q;
        logic [AMT_W-1:0] a_q;
        logic [1:0]       m_q;

        if (k == 0) begin : g_src_port
            assign src_valid[k] = in_valid;
            assign src_data[k]  = in_data;
            assign src_amt[k]   = in_amt;
            assign src_mode[k]  = in_mode;
            // The sign is frozen at entry so later stages fill with the original MSB.
            assign src_sign[k]  = in_data[WIDTH-1];
        end else begin : g_src_stage
            assign src_valid[k] = stg_valid[k-1];
            assign src_data[k]  = stg_data[k-1];
            assign src_amt[k]   = stg_amt[k-1];
            assign src_mode[k]  = stg_mode[k-1];
            assign src_sign[k]  = stg_sign[k-1];
        end

        if (k == AMT_W - 1) begin : g_adv_out
            assign advance[k] = v_q && out_ready;
        end else begin : g_adv_mid
            assign advance[k] = v_q && load[k+1];
        end

        // An empty stage always loads, which collapses bubbles under backpressure.
        assign load[k]     = !v_q || advance[k];
        assign stg_next[k] = src_amt[k][k] ? move(src_data[k], src_mode[k], src_sign[k], 1 << k)
                                           : src_data[k];

        always_ff @(posedge clk) begin
            if (!reset) begin
                v_q <= 1'b0;
                s_q <= 1'b0;
                d_q <= '0;
                a_q <= '0;
                m_q <= '0;
            end else if (load[k]) begin
                v_q <= src_valid[k];
                if (src_valid[k]) begin
                    s_q <= src_sign[k];
                    d_q <= stg_next[k];
                    a_q <= src_amt[k];
                    m_q <= src_mode[k];
                end
            end
        end

        assign stg_valid[k] = v_q;
        assign stg_sign[k]  = s_q;
        assign stg_data[k]  = d_q;
        assign stg_amt[k]   = a_q;
        assign stg_mode[k]  = m_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            zero_q <= 1'b0;
        end else if (load[AMT_W-1] && src_valid[AMT_W-1]) begin
            zero_q <= (stg_next[AMT_W-1] == '0);
        end
    end

    assign in_ready  = load[0];
    assign out_valid = stg_valid[AMT_W-1];
    assign out_data  = stg_data[AMT_W-1];
    assign out_zero  = stg_valid[AMT_W-1] && zero_q;

endmodule

// File: doc/pipelined_bit_rotator.md
Name: pipelined_bit_rotator

Overview:
- Parametrised successor to the team's single-bit registered rotator.
- Rotates or shifts a WIDTH-bit word by a variable amount (0..WIDTH-1) in one of four modes.
- Structured as a log2(WIDTH)-stage pipeline with a valid/ready handshake on both sides, so it accepts one word per cycle and respects downstream backpressure.
- Sits between datapath producers and consumers that need variable-distance rotation at full throughput.

Parameters:
- WIDTH, 8, data word width; must be a power of two, >= 2.
- AMT_W, $clog2(WIDTH), width of the shift-amount field and number of pipeline stages; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset: reset=0 at a clk rising edge resets the block
- in_valid  input  1  upstream word present
- in_ready  output  1  block accepts the word this cycle
- in_data  input  WIDTH  word to transform
- in_amt  input  AMT_W  shift/rotate distance
- in_mode  input  2  00 rotate left, 01 rotate right, 10 logical shift left, 11 arithmetic shift right
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  transformed word
- out_zero  output  1  out_data == 0, qualified by out_valid

Behaviour:
- Only one clock domain (clk). Reset is synchronous and active-low: it is sampled at the clk rising edge and acts when reset=0.
- Reset values:
  - All stage valid bits 0.
  - out_valid=0, out_data=0, out_zero=0.
  - in_ready=1 in the first cycle after reset deasserts.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Pipeline structure:
  - Stage k, for k=0..AMT_W-1, registers data, remaining amt bits, mode and a valid bit.
  - Stage k applies a move of 2^k positions when amt[k]=1 and passes the word unchanged when amt[k]=0.
  - The final stage drives out_* directly from registers; there is no combinational path from in_* to out_*.
- Latency is exactly AMT_W cycles from input transfer to out_valid when there is no stall (3 cycles for WIDTH=8). Throughput is one word per cycle.
- Stage movement:
  - Stage k loads from its upstream source when it is empty or its own contents advance this cycle. The upstream source is stage k-1, or the input port for k=0.
  - The last stage advances on an output transfer.
  - Bubbles collapse: an empty stage fills even while downstream is stalled.
  - in_ready = !valid[0] || advance[0]. in_ready may depend combinationally on out_ready, but never on in_valid.
- Stall behaviour: while out_valid=1 and out_ready=0, out_data, out_zero and out_valid hold stable. No word is dropped or duplicated.
- Mode arithmetic:
  - Rotate: bits that leave one end re-enter at the other end.
  - Logical shift left: zero fill.
  - Arithmetic shift right: fills with the original in_data MSB. The sign is captured at input and carried through the stages.
  - amt=0 passes the word unchanged in every mode.
- Ordering is strict FIFO; mode and amt travel with their word.
- Reset mid-operation: all in-flight words are discarded, with no partial output, and the block returns to the reset values above.
- in_valid/in_data may change freely while in_ready=0; nothing is captured.

Test Plan:
- WIDTH=8, after reset release, data 8'hB4, amt 1, mode 00 -> out_data 8'h69 exactly 3 cycles later, out_zero=0. Same data, amt 1, mode 01 -> 8'h5A.
- Back-to-back 8 words, out_ready=1: data 8'h81, amt 0..7, mode 00 -> 8 results on consecutive cycles: 81,03,06,0C,18,30,60,C0.
- Modes on 8'h96, amt 3: mode 10 -> 8'hB0; mode 11 -> 8'hF2; mode 11 on 8'h16, amt 3 -> 8'h02. Also mode 10 on 8'h80, amt 1 -> 8'h00 with out_zero=1.
- Backpressure: stream 5 words with out_ready=0 for 6 cycles -> in_ready drops after 3 words are accepted. out_data holds the first result stable. Releasing out_ready -> all 5 results emerge in order, none lost.
- Reset at 0 for one cycle while 3 words are in flight -> out_valid=0 and out_data=0 the next cycle, no stale word appears, in_ready=1.
- Randomised smoke, 1000 words, random in_valid/out_ready -> scoreboard match against a reference model for all modes and amounts.
